// File: rtl/dcsk_demodulator_if.sv
// Chip-stream / message handshake bundle for the DCSK demodulator.
interface dcsk_demodulator_if #(
    parameter int MSG_WIDTH = 32
);
    logic                 i_chip;
    logic                 i_chip_valid;
    logic                 i_start;
    logic [1:0]           i_spreading_factor;
    logic [MSG_WIDTH-1:0] o_msg;
    logic                 o_msg_valid;
    logic                 i_msg_ready;
    logic                 o_busy;
    logic                 o_overrun;

    // Driver side: chip front end plus message consumer
    modport master (
        output i_chip, i_chip_valid, i_start, i_spreading_factor, i_msg_ready,
        input  o_msg, o_msg_valid, o_busy, o_overrun
    );

    // Demodulator side
    modport slave (
        input  i_chip, i_chip_valid, i_start, i_spreading_factor, i_msg_ready,
        output o_msg, o_msg_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/dcsk_demodulator.sv
// DCSK receiver: stores each bit's reference half, counts data-half
// mismatches against it, hard-decides the bit, and assembles MSG_WIDTH
// bits into a message held in a valid/ready output register.
// SF code: 0/1/2/3 -> 2/4/8/16 chips per half.
module dcsk_demodulator #(
    parameter int MSG_WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    dcsk_demodulator_if.slave bus
);
    localparam int BW = $clog2(MSG_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, REF, DATA} state_e;

    state_e               state_q;
    logic [1:0]           sf_code_q;
    logic [15:0]          ref_buf_q;
    logic [3:0]           chip_idx_q;
    logic [4:0]           mismatch_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [MSG_WIDTH-1:0] sipo_q;
    logic [MSG_WIDTH-1:0] msg_q;
    logic                 msg_valid_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic [4:0]           sf_chips;
    logic [3:0]           last_idx;
    logic [4:0]           mismatch_d;
    logic                 bit_d;
    logic [MSG_WIDTH-1:0] sipo_d;
    logic                 last_chip;
    logic                 take_msg;

    // Decision path: mismatch total includes the current chip; a tie decides 0
    always_comb begin
        sf_chips   = 5'd2 << sf_code_q;
        last_idx   = 4'(sf_chips - 5'd1);
        mismatch_d = mismatch_q + {4'd0, bus.i_chip ^ ref_buf_q[chip_idx_q]};
        bit_d      = mismatch_d > (sf_chips >> 1);
        sipo_d     = {sipo_q[MSG_WIDTH-2:0], bit_d};
        last_chip  = (chip_idx_q == last_idx);
        take_msg   = !msg_valid_q || bus.i_msg_ready;
    end

    // Frame FSM, correlator counters and output message register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sf_code_q   <= 2'd0;
            ref_buf_q   <= '0;
            chip_idx_q  <= '0;
            mismatch_q  <= '0;
            bit_cnt_q   <= '0;
            sipo_q      <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            // Consumption; a completion load below in the same cycle wins
            if (msg_valid_q && bus.i_msg_ready)
                msg_valid_q <= 1'b0;

            if (bus.i_chip_valid) begin
                if (bus.i_start) begin
                    // Frame sync from any state: drop any partial frame, relatch SF
                    state_q      <= REF;
                    busy_q       <= 1'b1;
                    sf_code_q    <= bus.i_spreading_factor;
                    ref_buf_q[0] <= bus.i_chip;
                    chip_idx_q   <= 4'd1;
                    bit_cnt_q    <= '0;
                end else begin
                    case (state_q)
                        REF: begin
                            ref_buf_q[chip_idx_q] <= bus.i_chip;
                            if (last_chip) begin
                                chip_idx_q <= '0;
                                mismatch_q <= '0;
                                state_q    <= DATA;
                            end else begin
                                chip_idx_q <= chip_idx_q + 4'd1;
                            end
                        end
                        DATA: begin
                            mismatch_q <= mismatch_d;
                            if (last_chip) begin
                                sipo_q     <= sipo_d;
                                bit_cnt_q  <= bit_cnt_q + BW'(1);
                                chip_idx_q <= '0;
                                if (bit_cnt_q == BW'(MSG_WIDTH - 1)) begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    if (take_msg) begin
                                        msg_q       <= sipo_d;
                                        msg_valid_q <= 1'b1;
                                    end else begin
                                        overrun_q <= 1'b1;
                                    end
                                end else begin
                                    state_q <= REF;
                                end
                            end else begin
                                chip_idx_q <= chip_idx_q + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.o_msg       = msg_q;
    assign bus.o_msg_valid = msg_valid_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_dcsk_demodulator.sv
// Scoreboard bench for dcsk_demodulator: an 8-bit instance for most cases and
// a 32-bit instance for the SF16 frame; stimulus pushes expected messages,
// per-instance monitors pop and compare on each handshake.
module tb_dcsk_demodulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       chip = 1'b0, cv = 1'b0, st = 1'b0;
    logic [1:0] sf = 2'd0;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic       tgt = 1'b0;          // 0: 8-bit DUT, 1: 32-bit DUT
    bit         gaps = 1'b0;
    int         chip_cnt = 0, rdy_at = -1;
    logic       pre_busy, pre_valid;
    int         checks = 0, errors = 0;
    int         ovr_a = 0, ovr_b = 0;
    logic [31:0] exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    dcsk_demodulator_if #(.MSG_WIDTH(8))  ifa();
    dcsk_demodulator_if #(.MSG_WIDTH(32)) ifb();

    assign ifa.i_chip = chip;
    assign ifa.i_chip_valid = cv & ~tgt;
    assign ifa.i_start = st & ~tgt;
    assign ifa.i_spreading_factor = sf;
    assign ifa.i_msg_ready = rdy_a;
    assign ifb.i_chip = chip;
    assign ifb.i_chip_valid = cv & tgt;
    assign ifb.i_start = st & tgt;
    assign ifb.i_spreading_factor = sf;
    assign ifb.i_msg_ready = rdy_b;

    dcsk_demodulator #(.MSG_WIDTH(8))  dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    dcsk_demodulator #(.MSG_WIDTH(32)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: compare on every transfer, flag valid with nothing expected
    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.o_msg_valid && ifa.i_msg_ready) begin
                if (exp_a.size() == 0) chk("msg_a_unexpected", ifa.o_msg, 32'hxxxxxxxx);
                else chk("msg_a", 32'(ifa.o_msg), exp_a.pop_front());
            end
            if (ifb.o_msg_valid && ifb.i_msg_ready) begin
                if (exp_b.size() == 0) chk("msg_b_unexpected", ifb.o_msg, 32'hxxxxxxxx);
                else chk("msg_b", ifb.o_msg, exp_b.pop_front());
            end
            if (ifa.o_overrun) ovr_a++;
            if (ifb.o_overrun) ovr_b++;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_chip(input logic c, input logic s);
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        chip = c; st = s; cv = 1'b1;
        chip_cnt++;
        if (chip_cnt == rdy_at) rdy_a = 1'b1;
        pre_busy  = tgt ? ifb.o_busy : ifa.o_busy;
        pre_valid = tgt ? ifb.o_msg_valid : ifa.o_msg_valid;
        tick();
        cv = 1'b0; st = 1'b0;
    endtask

    // One message bit: n reference chips, then n data chips = ref ^ x
    task automatic send_bit(input logic [15:0] r, input logic [15:0] x, input int n, input bit first);
        for (int k = 0; k < n; k++) drive_chip(r[k], first && k == 0);
        for (int k = 0; k < n; k++) drive_chip(r[k] ^ x[k], 1'b0);
    endtask

    task automatic send_frame(input logic [31:0] msg, input int nbits, input logic [1:0] code,
                              input bit rnd, input bit chg_sf);
        int n;
        logic [15:0] r;
        n = 2 << code;
        sf = code;
        chip_cnt = 0;
        for (int i = nbits - 1; i >= 0; i--) begin
            r = rnd ? 16'($urandom) : 16'h000D;   // fixed ref chips 1,0,1,1
            send_bit(r, msg[i] ? 16'hFFFF : 16'h0000, n, i == nbits - 1);
            if (chg_sf) sf = 2'd0;
        end
    endtask

    initial begin
        int counts[8] = '{5, 4, 3, 5, 0, 8, 4, 3};
        int ovr0;
        logic [15:0] r;

        repeat (2) tick();
        chk("reset_msg_a", 32'(ifa.o_msg), 32'h0);
        chk("reset_valid_a", 32'(ifa.o_msg_valid), 32'h0);
        chk("reset_busy_a", 32'(ifa.o_busy), 32'h0);
        chk("reset_msg_b", ifb.o_msg, 32'h0);
        rst = 1'b0;
        tick();

        // SF4 noiseless 0xA5, held (ready low) so latency and hold can be seen
        rdy_a = 1'b0;
        send_frame(32'hA5, 8, 2'd1, 1'b0, 1'b0);
        chk("t1_pre_valid", 32'(pre_valid), 32'h0);
        chk("t1_pre_busy", 32'(pre_busy), 32'h1);
        chk("t1_valid_rise", 32'(ifa.o_msg_valid), 32'h1);
        chk("t1_busy_fall", 32'(ifa.o_busy), 32'h0);
        chk("t1_msg", 32'(ifa.o_msg), 32'hA5);
        exp_a.push_back(32'hA5);
        rdy_a = 1'b1;
        tick();
        tick();
        chk("t1_valid_clear", 32'(ifa.o_msg_valid), 32'h0);

        // SF16 32-bit frame, random refs, gaps, SF input changed mid-frame
        tgt = 1'b1; rdy_b = 1'b1; gaps = 1'b1;
        exp_b.push_back(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, 32, 2'd3, 1'b1, 1'b1);
        gaps = 1'b0;
        tick();
        tick();
        chk("t2_drained_b", exp_b.size(), 32'h0);
        tgt = 1'b0;

        // SF8 decision boundary: mismatches 5,4,3,5,0,8,4,3 -> 1,0,0,1,0,1,0,0
        sf = 2'd2;
        exp_a.push_back(32'h94);
        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom);
            send_bit(r, 16'((1 << counts[i]) - 1), 8, i == 0);
        end
        tick();
        tick();
        chk("t3_drained_a", exp_a.size(), 32'h0);

        // Backpressure: second frame dropped, one overrun
        rdy_a = 1'b0;
        ovr0 = ovr_a;
        exp_a.push_back(32'h11);
        send_frame(32'h11, 8, 2'd1, 1'b1, 1'b0);
        send_frame(32'h22, 8, 2'd1, 1'b1, 1'b0);
        tick();
        chk("bp_msg_held", 32'(ifa.o_msg), 32'h11);
        chk("bp_overrun_once", 32'(ovr_a - ovr0), 32'h1);
        rdy_a = 1'b1;
        tick();
        tick();
        chk("bp_valid_clear", 32'(ifa.o_msg_valid), 32'h0);

        // Backpressure released on the completion cycle: load, no overrun
        rdy_a = 1'b0;
        ovr0 = ovr_a;
        exp_a.push_back(32'h11);
        exp_a.push_back(32'h22);
        send_frame(32'h11, 8, 2'd1, 1'b1, 1'b0);
        rdy_at = 64;
        send_frame(32'h22, 8, 2'd1, 1'b1, 1'b0);
        rdy_at = -1;
        tick();
        tick();
        chk("bp2_no_overrun", 32'(ovr_a - ovr0), 32'h0);
        chk("bp2_drained", exp_a.size(), 32'h0);

        // Resync after 3 decoded bits, then a full 0x3C frame
        ovr0 = ovr_a;
        send_frame(32'h5, 3, 2'd1, 1'b1, 1'b0);
        exp_a.push_back(32'h3C);
        send_frame(32'h3C, 8, 2'd1, 1'b1, 1'b0);
        tick();
        tick();
        chk("resync_drained", exp_a.size(), 32'h0);
        chk("resync_no_overrun", 32'(ovr_a - ovr0), 32'h0);

        // Reset while a message is held and a frame is mid-DATA
        rdy_a = 1'b0;
        send_frame(32'h5A, 8, 2'd1, 1'b1, 1'b0);
        chk("rst_pre_valid", 32'(ifa.o_msg_valid), 32'h1);
        sf = 2'd1;
        for (int k = 0; k < 4; k++) drive_chip(k[0], k == 0);
        drive_chip(1'b1, 1'b0);
        drive_chip(1'b0, 1'b0);
        chk("rst_pre_busy", 32'(ifa.o_busy), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_msg", 32'(ifa.o_msg), 32'h0);
        chk("rst_valid", 32'(ifa.o_msg_valid), 32'h0);
        chk("rst_busy", 32'(ifa.o_busy), 32'h0);
        chk("rst_overrun", 32'(ifa.o_overrun), 32'h0);
        rst = 1'b0;
        rdy_a = 1'b1;
        exp_a.push_back(32'hC3);
        send_frame(32'hC3, 8, 2'd1, 1'b1, 1'b0);

        // Drain with a bounded wait
        for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) tick();
        chk("final_drain_a", exp_a.size(), 32'h0);
        chk("final_drain_b", exp_b.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
